// File: rtl/dm_cache_ctrl_if.sv
// Request/response bundle between the CPU, the cache controller and the
// SRAM memory controller.
//   cpu_req_*  : CPU request (valid/rw/addr/data), held until cpu_resp_ready
//   cpu_resp_* : one-cycle completion pulse and read data
//   mem_req_*  : one-cycle memory request pulse, fields held until response
//   mem_resp_* : one-cycle memory completion pulse and fill data
// slave  : the cache controller side
// master : the CPU/memory side (testbench or surrounding system)
interface dm_cache_ctrl_if #(
    parameter int ADDR_BITS = 20,
    parameter int DATA_BITS = 32
);
    logic                 cpu_req_valid;
    logic                 cpu_req_rw;
    logic [ADDR_BITS-1:0] cpu_req_addr;
    logic [DATA_BITS-1:0] cpu_req_data;
    logic                 cpu_resp_ready;
    logic [DATA_BITS-1:0] cpu_resp_data;
    logic                 mem_req_valid;
    logic                 mem_req_rw;
    logic [ADDR_BITS-1:0] mem_req_addr;
    logic [DATA_BITS-1:0] mem_req_data;
    logic                 mem_resp_ready;
    logic [DATA_BITS-1:0] mem_resp_data;

    modport slave (
        input  cpu_req_valid, cpu_req_rw, cpu_req_addr, cpu_req_data,
        input  mem_resp_ready, mem_resp_data,
        output cpu_resp_ready, cpu_resp_data,
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data
    );

    modport master (
        output cpu_req_valid, cpu_req_rw, cpu_req_addr, cpu_req_data,
        output mem_resp_ready, mem_resp_data,
        input  cpu_resp_ready, cpu_resp_data,
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data
    );
endinterface

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller, one word/line.
// Ports: clk, rst (sync, active-high); bus (dm_cache_ctrl_if.slave) carrying
// the CPU and memory handshakes; stat_hits/stat_misses saturating counters.
module dm_cache_ctrl #(
    parameter int ADDR_BITS  = 20,
    parameter int INDEX_BITS = 8,
    parameter int DATA_BITS  = 32,
    parameter int STAT_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    dm_cache_ctrl_if.slave       bus,
    output logic [STAT_BITS-1:0] stat_hits,
    output logic [STAT_BITS-1:0] stat_misses
);
    localparam int TAG_BITS = ADDR_BITS - INDEX_BITS;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        WRITE_BACK,
        ALLOCATE
    } state_t;

    state_t state, state_n;

    logic                 hold_rw;
    logic [ADDR_BITS-1:0] hold_addr;
    logic [DATA_BITS-1:0] hold_data;
    // set on accept, cleared in COMPARE: only the first look is counted
    logic                 first;

    logic [LINES-1:0]     valid;
    logic [LINES-1:0]     dirty;
    logic [TAG_BITS-1:0]  tag_mem  [LINES];
    logic [DATA_BITS-1:0] data_mem [LINES];

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   htag;
    logic                  hit;
    logic                  victim_dirty;

    logic accept, respond, start_wb, start_fill, wb_done, fill_done;

    assign idx          = hold_addr[INDEX_BITS-1:0];
    assign htag         = hold_addr[ADDR_BITS-1:INDEX_BITS];
    assign hit          = valid[idx] && (tag_mem[idx] == htag);
    assign victim_dirty = valid[idx] && dirty[idx];

    always_comb begin
        state_n    = state;
        accept     = 1'b0;
        respond    = 1'b0;
        start_wb   = 1'b0;
        start_fill = 1'b0;
        wb_done    = 1'b0;
        fill_done  = 1'b0;
        unique case (state)
            IDLE: begin
                // the response cycle still sees the old request held high
                if (bus.cpu_req_valid && !bus.cpu_resp_ready) begin
                    accept  = 1'b1;
                    state_n = COMPARE;
                end
            end
            COMPARE: begin
                // a write to a clean/invalid victim overwrites the whole
                // line, so it completes like a hit without a fetch
                if (hit || (hold_rw && !victim_dirty)) begin
                    respond = 1'b1;
                    state_n = IDLE;
                end else if (victim_dirty) begin
                    start_wb = 1'b1;
                    state_n  = WRITE_BACK;
                end else begin
                    start_fill = 1'b1;
                    state_n    = ALLOCATE;
                end
            end
            WRITE_BACK: begin
                if (bus.mem_resp_ready) begin
                    wb_done = 1'b1;
                    if (hold_rw) begin
                        state_n = COMPARE;
                    end else begin
                        start_fill = 1'b1;
                        state_n    = ALLOCATE;
                    end
                end
            end
            ALLOCATE: begin
                if (bus.mem_resp_ready) begin
                    fill_done = 1'b1;
                    state_n   = COMPARE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            hold_rw            <= 1'b0;
            hold_addr          <= '0;
            hold_data          <= '0;
            first              <= 1'b0;
            valid              <= '0;
            dirty              <= '0;
            stat_hits          <= '0;
            stat_misses        <= '0;
            bus.cpu_resp_ready <= 1'b0;
            bus.cpu_resp_data  <= '0;
            bus.mem_req_valid  <= 1'b0;
            bus.mem_req_rw     <= 1'b0;
            bus.mem_req_addr   <= '0;
            bus.mem_req_data   <= '0;
        end else begin
            state              <= state_n;
            bus.cpu_resp_ready <= 1'b0;
            bus.mem_req_valid  <= 1'b0;
            if (accept) begin
                hold_rw   <= bus.cpu_req_rw;
                hold_addr <= bus.cpu_req_addr;
                hold_data <= bus.cpu_req_data;
                first     <= 1'b1;
            end
            if (state == COMPARE) begin
                first <= 1'b0;
                if (first && hit && stat_hits != '1)
                    stat_hits <= stat_hits + 1'b1;
                if (first && !hit && stat_misses != '1)
                    stat_misses <= stat_misses + 1'b1;
            end
            if (respond) begin
                bus.cpu_resp_ready <= 1'b1;
                bus.cpu_resp_data  <= hold_rw ? hold_data : data_mem[idx];
                if (hold_rw) begin
                    valid[idx] <= 1'b1;
                    dirty[idx] <= 1'b1;
                end
            end
            if (start_wb) begin
                bus.mem_req_valid <= 1'b1;
                bus.mem_req_rw    <= 1'b1;
                bus.mem_req_addr  <= {tag_mem[idx], idx};
                bus.mem_req_data  <= data_mem[idx];
            end
            if (wb_done)
                dirty[idx] <= 1'b0;
            if (start_fill) begin
                bus.mem_req_valid <= 1'b1;
                bus.mem_req_rw    <= 1'b0;
                bus.mem_req_addr  <= hold_addr;
            end
            if (fill_done) begin
                valid[idx] <= 1'b1;
                dirty[idx] <= 1'b0;
            end
        end
    end

    // tag/data storage carries no reset; valid bits guard its contents
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (respond && hold_rw) begin
                tag_mem[idx]  <= htag;
                data_mem[idx] <= hold_data;
            end else if (fill_done) begin
                tag_mem[idx]  <= htag;
                data_mem[idx] <= bus.mem_resp_data;
            end
        end
    end
endmodule
